// File: rtl/mux_scan_controller.sv
// Sequencer that loads a 16-bit word into an external 16:1 mux and steps its select
// through every position, streaming the selected bit out over a valid/ready handshake.
module mux_scan_controller #(
  parameter int DWELL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        msb_first,
  output logic [15:0] mux_data,
  output logic [3:0]  mux_sel,
  input  logic        mux_out,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_bit,
  output logic        ser_last,
  output logic        busy
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_RELOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO     = CW'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            dir_r;
  logic [CW-1:0]   dwell_cnt_r;
  logic            accept_s;
  logic            dwell_done_s;
  logic            ser_hs_s;
  logic            final_sel_s;

  // Handshake decode and next-state selection.
  always_comb begin
    next_state_s = state_r;
    accept_s     = in_valid & in_ready;
    dwell_done_s = (dwell_cnt_r == CNT_ZERO);
    ser_hs_s     = ser_valid & ser_ready;
    // The final index ends the word, so the 4-bit select never wraps.
    if (dir_r) begin
      final_sel_s = (mux_sel == 4'd0);
    end else begin
      final_sel_s = (mux_sel == 4'd15);
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SETTLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETTLE: begin
        if (dwell_done_s) begin
          next_state_s = PRESENT;
        end else begin
          next_state_s = SETTLE;
        end
      end
      PRESENT: begin
        if (ser_hs_s) begin
          if (ser_last) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = SETTLE;
          end
        end else begin
          next_state_s = PRESENT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Status flags registered from the next state so they track the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_ready <= (next_state_s == IDLE);
      busy     <= (next_state_s != IDLE);
    end
  end

  // Word capture, select stepping, dwell timing and serial output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_data    <= 16'h0000;
      mux_sel     <= 4'd0;
      dir_r       <= 1'b0;
      dwell_cnt_r <= CNT_ZERO;
      ser_valid   <= 1'b0;
      ser_bit     <= 1'b0;
      ser_last    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mux_data    <= in_data;
            dir_r       <= msb_first;
            mux_sel     <= msb_first ? 4'd15 : 4'd0;
            dwell_cnt_r <= DWELL_RELOAD;
          end
        end
        SETTLE: begin
          if (dwell_done_s) begin
            ser_bit   <= mux_out;
            ser_last  <= final_sel_s;
            ser_valid <= 1'b1;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - CNT_ONE;
          end
        end
        PRESENT: begin
          if (ser_hs_s) begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            if (!ser_last) begin
              mux_sel     <= dir_r ? (mux_sel - 4'd1) : (mux_sel + 4'd1);
              dwell_cnt_r <= DWELL_RELOAD;
            end
          end
        end
        default: begin
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Randomised bench: a queue of expected (bit, last, select) triples per word is
// checked by an independent monitor at every serial handshake.
module tb_mux_scan_controller;
  localparam int DW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        msb_first = 1'b0;
  logic [15:0] mux_data;
  logic [3:0]  mux_sel;
  logic        mux_out;
  logic        ser_valid;
  logic        ser_ready = 1'b1;
  logic        ser_bit;
  logic        ser_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic rand_ready = 1'b0;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [3:0] sel;
  } exp_t;
  exp_t sb[$];

  // The external 16:1 mux.
  assign mux_out = mux_data[mux_sel];

  mux_scan_controller #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .msb_first(msb_first), .mux_data(mux_data),
    .mux_sel(mux_sel), .mux_out(mux_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_bit(ser_bit), .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mux_data"}, mux_data, 0);
    chk({tag, "_mux_sel"}, mux_sel, 0);
    chk({tag, "_ser_valid"}, ser_valid, 0);
    chk({tag, "_ser_bit"}, ser_bit, 0);
    chk({tag, "_ser_last"}, ser_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  // Release reset between edges; in_ready must rise only at the following edge.
  task automatic release_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    #1 chk("in_ready_at_release", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);
    chk("busy_after_release", busy, 0);
  endtask

  task automatic send_word(input logic [15:0] d, input logic m);
    int n;
    int idx;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; msb_first = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      idx = m ? 15 - k : k;
      e.b = d[idx];
      e.last = (k == 15);
      e.sel = idx[3:0];
      sb.push_back(e);
    end
    #1;
    in_valid = 1'($urandom_range(0, 1)); in_data = 16'hFFFF; msb_first = ~m;
    for (int j = 0; j < DW; j++) begin
      @(negedge clk);
      chk("settle_no_valid", ser_valid, 0);
      chk("settle_sel", mux_sel, m ? 4'd15 : 4'd0);
      chk("settle_busy", busy, 1);
      chk("settle_in_ready", in_ready, 0);
      chk("captured_data", mux_data, d);
      #1 in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_valid_latency", ser_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic mid_reset(input bit in_present);
    int n;
    send_word(16'($urandom), 1'($urandom_range(0, 1)));
    n = 0;
    while (n < 200 && !(in_present ? (ser_valid && !ser_ready) || (n > 3 && ser_valid)
                                   : (busy && !ser_valid))) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1 check_zero(in_present ? "rst_present" : "rst_settle");
    sb.delete();
    repeat (2) @(negedge clk);
    check_zero(in_present ? "rst_hold_present" : "rst_hold_settle");
    release_reset();
  endtask

  // Downstream ready: always accepting, or randomly throttled.
  initial begin
    forever begin
      @(posedge clk); #1;
      ser_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: every serial handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    logic expect_idle;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          chk("in_ready_after_last", in_ready, 1);
          chk("idle_after_last_busy", busy, 0);
          chk("idle_after_last_valid", ser_valid, 0);
          expect_idle = 1'b0;
        end
        if (ser_valid && ser_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bit: got bit %0b last %0b with nothing expected",
                     ser_bit, ser_last);
          end else begin
            e = sb.pop_front();
            chk("ser_bit", ser_bit, e.b);
            chk("ser_last", ser_last, e.last);
            chk("mux_sel", mux_sel, e.sel);
            chk("busy_while_valid", busy, 1);
            expect_idle = e.last;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    release_reset();
    send_word(16'hD3A7, 1'b0);
    send_word(16'hD3A7, 1'b1);
    send_word(16'h0001, 1'b0);
    drain();
    rand_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      send_word(16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_ready = 1'b0;
    mid_reset(1'b0);
    mid_reset(1'b1);
    send_word(16'h8000, 1'b1);
    send_word(16'h7FFE, 1'b0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
